// File: rtl/nyq_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel Nyquist FIR.
package nyq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } nyq_state_t;

    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span = 1;
        while (span < value) begin
            span = span << 1;
            result++;
        end
        return result;
    endfunction

    // Index fields never collapse to zero width, even for a single channel or tap.
    function automatic int idx_width(input int count);
        return (count > 1) ? clog2(count) : 1;
    endfunction

    function automatic int acc_width(input int in_width, input int mem_width, input int num_taps);
        return in_width + mem_width + clog2(num_taps);
    endfunction

    function automatic longint round_const(input int frac_bits);
        return (frac_bits > 0) ? (longint'(1) << (frac_bits - 1)) : longint'(0);
    endfunction

endpackage

// File: rtl/nyq_round_sat.sv
// Round-half-up scaling of the accumulator followed by saturation to the output width.
module nyq_round_sat
    import nyq_pkg::*;
#(
    parameter int ACC_WIDTH = 54,
    parameter int OUT_WIDTH = 24,
    parameter int FRAC_BITS = 22
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [OUT_WIDTH-1:0] result,
    output logic                        clip
);

    // One guard bit keeps the rounding addition from wrapping at the accumulator extremes.
    localparam int SUM_WIDTH = ACC_WIDTH + 1;
    localparam logic signed [SUM_WIDTH-1:0] HALF = SUM_WIDTH'(round_const(FRAC_BITS));

    logic signed [SUM_WIDTH-1:0]   sum;
    logic signed [SUM_WIDTH-1:0]   scaled;
    logic [SUM_WIDTH-OUT_WIDTH:0]  head;

    always_comb begin
        sum    = $signed({acc[ACC_WIDTH-1], acc}) + HALF;
        scaled = sum >>> FRAC_BITS;
        // The value fits only if every bit above the output sign bit copies it.
        head   = scaled[SUM_WIDTH-1:OUT_WIDTH-1];
        clip   = !((&head) || !(|head));
        if (clip) begin
            result = scaled[SUM_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                         : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else begin
            result = scaled[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/nyq_fir_mc.sv
// Time-multiplexed multi-channel FIR: loadable coefficients, per-channel circular
// delay lines, one shared MAC and a rounded, saturated, strobed output.
module nyq_fir_mc
    import nyq_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int MEM_WIDTH  = 24,
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 24,
    parameter int NUM_TAPS   = 33,
    parameter int NUM_CH     = 2,
    parameter int FRAC_BITS  = 22
) (
    input  logic                               Clk_CI,
    input  logic                               Rst_RI,
    input  logic                               WrEn_SI,
    input  logic [ADDR_WIDTH-1:0]              Addr_DI,
    input  logic signed [MEM_WIDTH-1:0]        PAR_In_DI,
    input  logic                               NYQ_Valid_SI,
    output logic                               NYQ_Ready_SO,
    input  logic [idx_width(NUM_CH)-1:0]       NYQ_Ch_DI,
    input  logic signed [IN_WIDTH-1:0]         NYQ_In_DI,
    output logic                               NYQ_Valid_SO,
    output logic [idx_width(NUM_CH)-1:0]       NYQ_Ch_SO,
    output logic signed [OUT_WIDTH-1:0]        NYQ_Out_DO,
    output logic                               Sat_SO
);

    localparam int CH_WIDTH   = idx_width(NUM_CH);
    localparam int TAP_WIDTH  = idx_width(NUM_TAPS);
    localparam int ACC_WIDTH  = acc_width(IN_WIDTH, MEM_WIDTH, NUM_TAPS);
    localparam int PROD_WIDTH = IN_WIDTH + MEM_WIDTH;

    localparam logic [ADDR_WIDTH:0]  TAPS_ADDR = (ADDR_WIDTH + 1)'(NUM_TAPS);
    localparam logic [TAP_WIDTH:0]   TAPS_EXT  = (TAP_WIDTH + 1)'(NUM_TAPS);
    localparam logic [TAP_WIDTH-1:0] LAST_TAP  = TAP_WIDTH'(NUM_TAPS - 1);
    localparam logic [TAP_WIDTH-1:0] TAP_ONE   = TAP_WIDTH'(1);
    localparam logic [CH_WIDTH:0]    CH_COUNT  = (CH_WIDTH + 1)'(NUM_CH);

    nyq_state_t state;
    nyq_state_t state_next;

    logic signed [MEM_WIDTH-1:0]  coef [NUM_TAPS];
    logic signed [IN_WIDTH-1:0]   delay_line [NUM_CH][NUM_TAPS];
    logic [TAP_WIDTH-1:0]         wp [NUM_CH];

    logic [CH_WIDTH-1:0]          ch_q;
    logic [TAP_WIDTH-1:0]         k_q;
    logic signed [ACC_WIDTH-1:0]  acc;

    logic                         start;
    logic                         coef_write;
    logic [TAP_WIDTH-1:0]         wp_cur;
    logic [TAP_WIDTH-1:0]         rd_idx;
    logic signed [MEM_WIDTH-1:0]  tap_coef;
    logic signed [IN_WIDTH-1:0]   tap_sample;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [OUT_WIDTH-1:0]  rs_result;
    logic                         rs_clip;

    // An out-of-range channel still handshakes, but never starts a computation.
    assign start      = NYQ_Valid_SI && NYQ_Ready_SO && ({1'b0, NYQ_Ch_DI} < CH_COUNT);
    assign coef_write = WrEn_SI && ({1'b0, Addr_DI} < TAPS_ADDR);

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MAC;
            MAC:     if (k_q == LAST_TAP) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        NYQ_Ready_SO = (state == IDLE) && !Rst_RI;
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (coef_write) begin
            coef[Addr_DI] <= PAR_In_DI;
        end
    end

    // Tap k reads the sample written k acceptances ago on the active channel.
    always_comb begin
        wp_cur = wp[ch_q];
        if (wp_cur >= k_q) begin
            rd_idx = wp_cur - k_q;
        end else begin
            rd_idx = TAP_WIDTH'(({1'b0, wp_cur} + TAPS_EXT) - {1'b0, k_q});
        end
        tap_coef   = coef[k_q];
        tap_sample = delay_line[ch_q][rd_idx];
        prod       = tap_coef * tap_sample;
    end

    nyq_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
        .acc    (acc),
        .result (rs_result),
        .clip   (rs_clip)
    );

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wp[c] <= '0;
                for (int t = 0; t < NUM_TAPS; t++) begin
                    delay_line[c][t] <= '0;
                end
            end
            ch_q         <= '0;
            k_q          <= '0;
            acc          <= '0;
            NYQ_Valid_SO <= 1'b0;
            Sat_SO       <= 1'b0;
            NYQ_Ch_SO    <= '0;
            NYQ_Out_DO   <= '0;
        end else begin
            NYQ_Valid_SO <= 1'b0;
            Sat_SO       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ch_q                             <= NYQ_Ch_DI;
                        delay_line[NYQ_Ch_DI][wp[NYQ_Ch_DI]] <= NYQ_In_DI;
                        acc                              <= '0;
                        k_q                              <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_WIDTH'(prod);
                    k_q <= k_q + TAP_ONE;
                end
                OUT: begin
                    NYQ_Out_DO   <= rs_result;
                    Sat_SO       <= rs_clip;
                    NYQ_Ch_SO    <= ch_q;
                    NYQ_Valid_SO <= 1'b1;
                    wp[ch_q]     <= (wp_cur == LAST_TAP) ? '0 : wp_cur + TAP_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nyq_fir_mc.sv
// Directed bench for nyq_fir_mc: identity, impulse ramp, channel isolation,
// saturation, rounding and reset abort, each against hand-computed results.
module tb_nyq_fir_mc;

    // The impulse ramp needs coefficients up to 33.0 in Q22, beyond a 24-bit signed word.
    localparam int MEM_W   = 32;
    localparam int LATENCY = 34;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_en;
    logic [5:0]          addr;
    logic signed [MEM_W-1:0] par_in;
    logic                valid_si;
    logic                ready;
    logic [0:0]          ch_di;
    logic signed [23:0]  in_di;
    logic                valid_so;
    logic [0:0]          ch_so;
    logic signed [23:0]  out_do;
    logic                sat;

    int n_checks = 0;
    int n_pass   = 0;

    nyq_fir_mc #(
        .ADDR_WIDTH (6),
        .MEM_WIDTH  (MEM_W),
        .IN_WIDTH   (24),
        .OUT_WIDTH  (24),
        .NUM_TAPS   (33),
        .NUM_CH     (2),
        .FRAC_BITS  (22)
    ) dut (
        .Clk_CI       (clk),
        .Rst_RI       (rst),
        .WrEn_SI      (wr_en),
        .Addr_DI      (addr),
        .PAR_In_DI    (par_in),
        .NYQ_Valid_SI (valid_si),
        .NYQ_Ready_SO (ready),
        .NYQ_Ch_DI    (ch_di),
        .NYQ_In_DI    (in_di),
        .NYQ_Valid_SO (valid_so),
        .NYQ_Ch_SO    (ch_so),
        .NYQ_Out_DO   (out_do),
        .Sat_SO       (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] observed,
                         input logic signed [63:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic apply_reset(input int cycles);
        rst      = 1'b1;
        wr_en    = 1'b0;
        valid_si = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check("ready_in_reset", 64'(ready), 64'(0));
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic write_coef(input int a, input longint d);
        wr_en  = 1'b1;
        addr   = 6'(a);
        par_in = MEM_W'(d);
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
    endtask

    // Sends one sample and checks handshake, latency, result, channel and clip flag.
    task automatic apply_stimulus(input string tag, input logic ch,
                                  input logic signed [63:0] x,
                                  input logic signed [63:0] exp_out,
                                  input logic exp_sat);
        int cycles;
        bit seen;
        check({tag, "_ready_idle"}, 64'(ready), 64'(1));
        valid_si = 1'b1;
        ch_di    = ch;
        in_di    = x[23:0];
        @(posedge clk);
        #1;
        valid_si = 1'b0;
        check({tag, "_ready_busy"}, 64'(ready), 64'(0));
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (valid_so === 1'b1) seen = 1'b1;
        end
        check({tag, "_latency"}, 64'(cycles), 64'(LATENCY));
        check_output(tag, exp_out, exp_sat, ch);
        @(posedge clk);
        #1;
        check({tag, "_strobe_end"}, 64'(valid_so), 64'(0));
    endtask

    task automatic check_output(input string tag, input logic signed [63:0] exp_out,
                                input logic exp_sat, input logic exp_ch);
        check({tag, "_out"}, 64'(out_do), exp_out);
        check({tag, "_sat"}, 64'(sat), 64'(exp_sat));
        check({tag, "_ch"}, 64'(ch_so), 64'(exp_ch));
    endtask

    initial begin
        int pulses;
        rst      = 1'b1;
        wr_en    = 1'b0;
        addr     = '0;
        par_in   = '0;
        valid_si = 1'b0;
        ch_di    = '0;
        in_di    = '0;

        $display("[TB] reset state");
        apply_reset(2);
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_valid", 64'(valid_so), 64'(0));
        check("rst_out", 64'(out_do), 64'(0));
        check("rst_sat", 64'(sat), 64'(0));
        check("rst_ch", 64'(ch_so), 64'(0));

        $display("[TB] identity");
        write_coef(0, 4194304);
        apply_stimulus("id0", 1'b0, 64'sd5, 64'sd5, 1'b0);
        apply_stimulus("id1", 1'b0, -64'sd7, -64'sd7, 1'b0);
        apply_stimulus("id2", 1'b0, 64'sd8388607, 64'sd8388607, 1'b0);

        $display("[TB] impulse ramp with pointer wrap");
        apply_reset(1);
        for (int k = 0; k < 33; k++) write_coef(k, longint'(k + 1) << 22);
        for (int n = 0; n < 35; n++) begin
            apply_stimulus($sformatf("imp%0d", n), 1'b0,
                           (n == 0) ? 64'sd1 : 64'sd0,
                           (n < 33) ? 64'(n + 1) : 64'sd0, 1'b0);
        end

        $display("[TB] channel isolation");
        apply_reset(1);
        for (int k = 0; k < 33; k++) write_coef(k, longint'(k + 1) << 22);
        for (int n = 0; n < 4; n++) begin
            apply_stimulus($sformatf("iso0_%0d", n), 1'b0,
                           (n == 0) ? 64'sd1 : 64'sd0, 64'(n + 1), 1'b0);
            apply_stimulus($sformatf("iso1_%0d", n), 1'b1,
                           (n == 0) ? 64'sd1000 : 64'sd0, 64'(1000 * (n + 1)), 1'b0);
        end

        $display("[TB] saturation");
        apply_reset(1);
        write_coef(0, 4194304);
        write_coef(1, 4194304);
        apply_stimulus("satp0", 1'b0, 64'sd8388607, 64'sd8388607, 1'b0);
        apply_stimulus("satp1", 1'b0, 64'sd8388607, 64'sd8388607, 1'b1);
        apply_stimulus("satn0", 1'b0, -64'sd8388608, -64'sd1, 1'b0);
        apply_stimulus("satn1", 1'b0, -64'sd8388608, -64'sd8388608, 1'b1);

        $display("[TB] rounding and ignored writes");
        apply_reset(1);
        write_coef(0, 2097152);
        write_coef(40, 4194304);
        write_coef(33, 4194304);
        apply_stimulus("rnd_p3", 1'b0, 64'sd3, 64'sd2, 1'b0);
        apply_stimulus("rnd_m3", 1'b0, -64'sd3, -64'sd1, 1'b0);
        apply_stimulus("rnd_p2", 1'b0, 64'sd2, 64'sd1, 1'b0);

        $display("[TB] reset during MAC");
        valid_si = 1'b1;
        ch_di    = 1'b1;
        in_di    = 24'sd100;
        @(posedge clk);
        #1;
        valid_si = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready_in_reset", 64'(ready), 64'(0));
        rst = 1'b0;
        #1;
        check("abort_ready", 64'(ready), 64'(1));
        check("abort_valid", 64'(valid_so), 64'(0));
        check_output("abort", 64'sd0, 1'b0, 1'b0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid_so === 1'b1) pulses++;
        end
        check("abort_no_pulse", 64'(pulses), 64'(0));
        apply_stimulus("post_abort", 1'b0, 64'sd1, 64'sd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
